// File: rtl/shift_frame_pkg.sv
// Shared types and widths for the shift-register frame controller.
package shift_frame_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_t;

   localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/shift_frame_ctrl.sv
// Serializes handshaked parallel words into load/shift commands for a
// parallel-load shift register, with an inter-frame gap and frame counter.
module shift_frame_ctrl
   import shift_frame_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 1,
   parameter logic        FILL_BIT   = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [WIDTH-1:0]       s_data,
   input  logic                   s_lsb_first,
   output logic                   sr_load_en,
   output logic                   sr_shift_en,
   output logic                   sr_direction,
   output logic [WIDTH-1:0]       sr_parallel_in,
   output logic                   sr_serial_in,
   output logic                   busy,
   output logic                   frame_done,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam int unsigned CNT_W = ($clog2(WIDTH) > 8) ? $clog2(WIDTH) : 8;
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   dir_q, dir_d;
   logic                   frame_done_q, frame_done_d;
   logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

   // Next-state, counter and capture logic; flush overrides all transitions.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      data_d        = data_q;
      dir_d         = dir_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q + FRAME_CNT_W'(frame_done_q);

      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (s_valid) begin
                  data_d  = s_data;
                  dir_d   = s_lsb_first;
                  state_d = LOAD;
               end
            end
            LOAD: begin
               cnt_d   = '0;
               state_d = SHIFT;
            end
            SHIFT: begin
               if (cnt_q == SHIFT_LAST) begin
                  cnt_d        = '0;
                  frame_done_d = 1'b1;
                  state_d      = (GAP_CYCLES > 0) ? GAP : IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         data_q        <= '0;
         dir_q         <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         data_q        <= data_d;
         dir_q         <= dir_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Moore decode of commands from the registered state.
   assign s_ready        = (state_q == IDLE) && !flush;
   assign busy           = (state_q != IDLE);
   assign sr_load_en     = (state_q == LOAD);
   assign sr_shift_en    = (state_q == SHIFT);
   assign sr_direction   = dir_q;
   assign sr_parallel_in = data_q;
   assign sr_serial_in   = FILL_BIT;
   assign frame_done     = frame_done_q;
   assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Randomized self-checking bench for shift_frame_ctrl against a cycle-offset
// reference model; one instance with a 1-cycle gap, one with no gap.
module tb_shift_frame_ctrl;

   localparam int unsigned W = 8;
   localparam logic [30:0] RESET_OBS = 31'h4000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         s_valid = 1'b0;
   logic [W-1:0] s_data = '0;
   logic         s_lsb_first = 1'b0;
   logic         sel = 1'b0;

   logic         rdy0, ld0, sh0, dir0, ser0, busy0, done0;
   logic [W-1:0] par0;
   logic [15:0]  cnt0;
   logic         rdy1, ld1, sh1, dir1, ser1, busy1, done1;
   logic [W-1:0] par1;
   logic [15:0]  cnt1;
   logic         sv0, sv1;

   assign sv0 = s_valid && !sel;
   assign sv1 = s_valid && sel;

   shift_frame_ctrl #(.WIDTH(W), .GAP_CYCLES(1), .FILL_BIT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .s_valid(sv0), .s_ready(rdy0),
      .s_data(s_data), .s_lsb_first(s_lsb_first), .sr_load_en(ld0),
      .sr_shift_en(sh0), .sr_direction(dir0), .sr_parallel_in(par0),
      .sr_serial_in(ser0), .busy(busy0), .frame_done(done0), .frame_count(cnt0)
   );

   shift_frame_ctrl #(.WIDTH(W), .GAP_CYCLES(0), .FILL_BIT(1'b0)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .s_valid(sv1), .s_ready(rdy1),
      .s_data(s_data), .s_lsb_first(s_lsb_first), .sr_load_en(ld1),
      .sr_shift_en(sh1), .sr_direction(dir1), .sr_parallel_in(par1),
      .sr_serial_in(ser1), .busy(busy1), .frame_done(done1), .frame_count(cnt1)
   );

   logic         o_rdy, o_ld, o_sh, o_dir, o_ser, o_busy, o_done;
   logic [W-1:0] o_par;
   logic [15:0]  o_cnt;
   logic [30:0]  obs;

   assign o_rdy  = sel ? rdy1  : rdy0;
   assign o_ld   = sel ? ld1   : ld0;
   assign o_sh   = sel ? sh1   : sh0;
   assign o_dir  = sel ? dir1  : dir0;
   assign o_ser  = sel ? ser1  : ser0;
   assign o_busy = sel ? busy1 : busy0;
   assign o_done = sel ? done1 : done0;
   assign o_par  = sel ? par1  : par0;
   assign o_cnt  = sel ? cnt1  : cnt0;
   assign obs    = {o_rdy, o_ld, o_sh, o_dir, o_par, o_ser, o_busy, o_done, o_cnt};

   // Reference model: m_t counts cycles since the accepting edge (1 = load cycle).
   bit           m_active = 1'b0;
   int           m_t = 0;
   bit           m_done = 1'b0;
   logic [W-1:0] m_data = '0;
   bit           m_dir = 1'b0;
   logic [15:0]  m_count = '0;
   bit           last_hs = 1'b0;
   int           cyc = 0;
   int           n_vec = 0;
   int           n_err = 0;

   function automatic int gap();
      return sel ? 0 : 1;
   endfunction

   function automatic bit exp_busy();
      return m_active && (m_t >= 1) && (m_t <= int'(W) + 1 + gap());
   endfunction

   function automatic logic [30:0] exp_obs();
      bit b, ld, sh, rdy;
      b   = exp_busy();
      ld  = m_active && (m_t == 1);
      sh  = m_active && (m_t >= 2) && (m_t <= int'(W) + 1);
      rdy = !b && !flush;
      return {rdy, ld, sh, m_dir, m_data, 1'b0, b, m_done, m_count};
   endfunction

   task automatic tick();
      bit hs, done_next;
      hs        = s_valid && !exp_busy() && !flush && !rst;
      done_next = m_active && (m_t == int'(W) + 1) && !flush && !rst;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_active = 1'b0;
         m_t      = 0;
         m_done   = 1'b0;
         m_data   = '0;
         m_dir    = 1'b0;
         m_count  = '0;
      end else begin
         if (m_done) m_count = m_count + 16'd1;
         m_done = done_next;
         if (flush) begin
            m_active = 1'b0;
         end else if (hs) begin
            m_active = 1'b1;
            m_t      = 1;
            m_data   = s_data;
            m_dir    = s_lsb_first;
         end else if (m_active) begin
            m_t++;
         end
      end
      last_hs = hs;
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      flush   = 1'b0;
      s_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      sel         = 1'b0;
      rst         = 1'b1;
      s_valid     = 1'b1;
      s_data      = W'($urandom);
      s_lsb_first = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_vec++;
      if (obs !== RESET_OBS) begin
         n_err++;
         $display("FAIL reset_values got=%h exp=%h", obs, RESET_OBS);
      end
      n_vec++;
      if (obs !== exp_obs()) begin
         n_err++;
         $display("FAIL reset_model got=%h exp=%h", obs, exp_obs());
      end
      rst     = 1'b0;
      s_valid = 1'b0;
      tick();
   endtask

   task automatic test_lsb_frame();
      int loads, shifts, done_at;
      sel = 1'b0;
      do_reset();
      loads = 0; shifts = 0; done_at = -1;
      s_data      = 8'hA5;
      s_lsb_first = 1'b1;
      s_valid     = 1'b1;
      tick();
      s_valid = 1'b0;
      s_data  = W'($urandom);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         n_vec++;
         if (obs !== exp_obs()) begin
            n_err++;
            $display("FAIL lsb_frame k=%0d got=%h exp=%h", k, obs, exp_obs());
         end
         if (o_ld) begin
            loads++;
            n_vec++;
            if (o_par !== 8'hA5 || o_dir !== 1'b1) begin
               n_err++;
               $display("FAIL lsb_load_word got=%h/%b exp=a5/1", o_par, o_dir);
            end
         end
         if (o_sh) shifts++;
         if (o_done) done_at = k;
         tick();
      end
      n_vec++;
      if (loads !== 1 || shifts !== 8) begin
         n_err++;
         $display("FAIL lsb_pulses got load=%0d shift=%0d exp load=1 shift=8", loads, shifts);
      end
      n_vec++;
      if (done_at !== 10) begin
         n_err++;
         $display("FAIL lsb_done_latency got=%0d exp=10", done_at);
      end
      @(negedge clk);
      n_vec++;
      if (o_cnt !== 16'd1) begin
         n_err++;
         $display("FAIL lsb_count got=%0d exp=1", o_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int hs_cyc[2];
      int nhs, dir_changes;
      logic prev_dir;
      sel = 1'b1;
      do_reset();
      nhs = 0; dir_changes = 0;
      prev_dir    = 1'b0;
      s_data      = 8'h3C;
      s_lsb_first = 1'b0;
      s_valid     = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         n_vec++;
         if (obs !== exp_obs()) begin
            n_err++;
            $display("FAIL b2b k=%0d got=%h exp=%h", k, obs, exp_obs());
         end
         if (o_dir !== prev_dir) dir_changes++;
         prev_dir = o_dir;
         tick();
         if (last_hs && nhs < 2) begin
            hs_cyc[nhs] = cyc;
            nhs++;
            s_data      = 8'hC3;
            s_lsb_first = 1'b1;
            if (nhs == 2) s_valid = 1'b0;
         end
      end
      n_vec++;
      if (nhs !== 2 || (hs_cyc[1] - hs_cyc[0]) !== 10) begin
         n_err++;
         $display("FAIL b2b_spacing got hs=%0d gap=%0d exp hs=2 gap=10", nhs,
                  (nhs == 2) ? hs_cyc[1] - hs_cyc[0] : -1);
      end
      n_vec++;
      if (dir_changes !== 1) begin
         n_err++;
         $display("FAIL b2b_dir_changes got=%0d exp=1", dir_changes);
      end
      @(negedge clk);
      n_vec++;
      if (o_cnt !== 16'd2) begin
         n_err++;
         $display("FAIL b2b_count got=%0d exp=2", o_cnt);
      end
   endtask

   task automatic test_flush_shift();
      logic [W-1:0] word;
      int dones;
      sel = 1'b0;
      do_reset();
      dones       = 0;
      word        = W'($urandom);
      s_data      = word;
      s_lsb_first = 1'($urandom);
      s_valid     = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int k = 1; k < 5; k++) tick();
      flush = 1'b1;
      @(negedge clk);
      n_vec++;
      if (obs !== exp_obs() || o_sh !== 1'b1) begin
         n_err++;
         $display("FAIL flush_cycle got=%h exp=%h", obs, exp_obs());
      end
      tick();
      flush = 1'b0;
      @(negedge clk);
      n_vec++;
      if (o_busy !== 1'b0 || o_sh !== 1'b0 || o_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL flush_idle got busy=%b shift=%b ready=%b exp 0/0/1", o_busy, o_sh, o_rdy);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         n_vec++;
         if (obs !== exp_obs()) begin
            n_err++;
            $display("FAIL flush_after k=%0d got=%h exp=%h", k, obs, exp_obs());
         end
         if (o_done) dones++;
         tick();
      end
      @(negedge clk);
      n_vec++;
      if (dones !== 0 || o_cnt !== 16'd0 || o_par !== word) begin
         n_err++;
         $display("FAIL flush_abort got done=%0d cnt=%0d par=%h exp 0/0/%h", dones, o_cnt, o_par, word);
      end
   endtask

   task automatic test_flush_idle();
      logic [W-1:0] old_word, new_word;
      sel = 1'b0;
      @(negedge clk);
      old_word = o_par;
      new_word = ~old_word;
      flush       = 1'b1;
      s_valid     = 1'b1;
      s_data      = new_word;
      s_lsb_first = 1'b1;
      #1;
      n_vec++;
      if (o_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle_ready got=%b exp=0", o_rdy);
      end
      tick();
      @(negedge clk);
      n_vec++;
      if (o_par !== old_word || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle_capture got par=%h busy=%b exp %h/0", o_par, o_busy, old_word);
      end
      flush = 1'b0;
      #1;
      n_vec++;
      if (o_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL flush_idle_release got=%b exp=1", o_rdy);
      end
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (o_ld !== 1'b1 || o_par !== new_word || obs !== exp_obs()) begin
         n_err++;
         $display("FAIL flush_idle_accept got=%h exp=%h", obs, exp_obs());
      end
      for (int k = 0; k < 12; k++) tick();
   endtask

   task automatic test_reset_mid();
      sel = 1'b1;
      s_data      = W'($urandom) | 8'h01;
      s_lsb_first = 1'b1;
      s_valid     = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      n_vec++;
      if (obs !== RESET_OBS) begin
         n_err++;
         $display("FAIL reset_mid got=%h exp=%h", obs, RESET_OBS);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         do_reset();
         for (int k = 0; k < 300; k++) begin
            s_valid     = ($urandom_range(0, 1) == 1);
            s_data      = W'($urandom);
            s_lsb_first = 1'($urandom);
            flush       = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            n_vec++;
            if (obs !== exp_obs()) begin
               n_err++;
               $display("FAIL random sel=%0d k=%0d got=%h exp=%h", s, k, obs, exp_obs());
            end
            tick();
         end
         flush   = 1'b0;
         s_valid = 1'b0;
      end
   endtask

   task automatic test_wrap();
      bit seen_wrap;
      logic [15:0] prev_cnt;
      sel = 1'b1;
      do_reset();
      seen_wrap = 1'b0;
      @(negedge clk);
      force dut1.frame_count_q = 16'hFFFE;
      tick();
      release dut1.frame_count_q;
      m_count = 16'hFFFE;
      prev_cnt = 16'hFFFE;
      s_valid = 1'b1;
      for (int k = 0; k < 35; k++) begin
         s_data      = W'($urandom);
         s_lsb_first = 1'($urandom);
         tick();
         @(negedge clk);
         n_vec++;
         if (obs !== exp_obs()) begin
            n_err++;
            $display("FAIL wrap k=%0d got=%h exp=%h", k, obs, exp_obs());
         end
         if (prev_cnt == 16'hFFFF && o_cnt == 16'h0000) seen_wrap = 1'b1;
         prev_cnt = o_cnt;
      end
      s_valid = 1'b0;
      n_vec++;
      if (!seen_wrap || o_cnt !== 16'h0001) begin
         n_err++;
         $display("FAIL wrap_final got cnt=%h wrapped=%b exp 0001/1", o_cnt, seen_wrap);
      end
   endtask

   initial begin
      test_reset();
      test_lsb_frame();
      test_back_to_back();
      test_flush_shift();
      test_flush_idle();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
